// File: rtl/buffer_writer.sv
// Character-buffer writer: turns a byte stream into cell writes with cursor, CR/LF/BS/FF handling.
// Optional macro AUTOWRAP_EN: a printable byte at the last column wraps to the next row and clears it.
module buffer_writer #(
    parameter int unsigned COLS = 80,
    parameter int unsigned ROWS = 24
) (
    input  logic        pclk,
    input  logic        clr,
    input  logic [7:0]  data,
    input  logic        valid,
    output logic        ready,
    output logic [10:0] buffer_addr,
    output logic [7:0]  buffer_din,
    output logic        buffer_wen,
    output logic [6:0]  cursor_col,
    output logic [4:0]  cursor_row
);

    localparam int unsigned CNT_W  = 12;
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned COL_W  = 7;
    localparam int unsigned ROW_W  = 5;

    localparam logic [CNT_W-1:0]  L_COLS_CNT  = CNT_W'(COLS);
    localparam logic [CNT_W-1:0]  L_CELLS_CNT = CNT_W'(COLS * ROWS);
    localparam logic [ADDR_W-1:0] L_COLS_ADDR = ADDR_W'(COLS);
    localparam logic [COL_W-1:0]  L_LAST_COL  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  L_LAST_ROW  = ROW_W'(ROWS - 1);

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_TILDE = 8'h7E;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR_LINE,
        ST_CLEAR_SCREEN
    } state_t;

    state_t              r_state;
    logic                r_ready;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_din;
    logic                r_wen;
    logic [COL_W-1:0]    r_col;
    logic [ROW_W-1:0]    r_row;
    logic [ADDR_W-1:0]   r_row_base;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_xfer;
    logic                w_printable;
    logic                w_last_row;
    logic                w_last_col;
    logic [ROW_W-1:0]    w_next_row;
    logic [ADDR_W-1:0]   w_next_base;
    logic [ADDR_W-1:0]   w_char_addr;
    logic [ADDR_W-1:0]   w_line_addr;

    assign w_xfer      = valid & r_ready;
    assign w_printable = (data >= CH_SPACE) && (data <= CH_TILDE);
    assign w_last_row  = (r_row == L_LAST_ROW);
    assign w_last_col  = (r_col == L_LAST_COL);
    assign w_next_row  = w_last_row ? '0 : r_row + ROW_W'(1);
    // row_base tracks row*COLS incrementally so no multiplier is needed
    assign w_next_base = w_last_row ? '0 : r_row_base + L_COLS_ADDR;
    assign w_char_addr = r_row_base + ADDR_W'(r_col);
    assign w_line_addr = r_row_base + ADDR_W'(r_cnt);

    assign ready       = r_ready;
    assign buffer_addr = r_addr;
    assign buffer_din  = r_din;
    assign buffer_wen  = r_wen;
    assign cursor_col  = r_col;
    assign cursor_row  = r_row;

    always_ff @(posedge pclk) begin
        if (clr) begin
            r_state    <= ST_IDLE;
            r_ready    <= 1'b0;
            r_addr     <= '0;
            r_din      <= '0;
            r_wen      <= 1'b0;
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= '0;
            r_cnt      <= '0;
        end else begin
            r_wen <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b1;
                    if (w_xfer) begin
                        if (w_printable) begin
                            r_wen  <= 1'b1;
                            r_addr <= w_char_addr;
                            r_din  <= data;
`ifdef AUTOWRAP_EN
                            if (w_last_col) begin
                                r_col      <= '0;
                                r_row      <= w_next_row;
                                r_row_base <= w_next_base;
                                r_cnt      <= '0;
                                r_state    <= ST_CLEAR_LINE;
                                r_ready    <= 1'b0;
                            end else begin
                                r_col <= r_col + COL_W'(1);
                            end
`else
                            if (!w_last_col) begin
                                r_col <= r_col + COL_W'(1);
                            end
`endif
                        end else begin
                            case (data)
                                CH_CR: r_col <= '0;
                                CH_BS: if (r_col != '0) r_col <= r_col - COL_W'(1);
                                // first clear write issues with the LF so the line takes exactly COLS cycles
                                CH_LF: begin
                                    r_row      <= w_next_row;
                                    r_row_base <= w_next_base;
                                    r_wen      <= 1'b1;
                                    r_addr     <= w_next_base;
                                    r_din      <= CH_SPACE;
                                    r_cnt      <= CNT_W'(1);
                                    r_state    <= ST_CLEAR_LINE;
                                    r_ready    <= 1'b0;
                                end
                                CH_FF: begin
                                    r_wen   <= 1'b1;
                                    r_addr  <= '0;
                                    r_din   <= CH_SPACE;
                                    r_cnt   <= CNT_W'(1);
                                    r_state <= ST_CLEAR_SCREEN;
                                    r_ready <= 1'b0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ST_CLEAR_LINE: begin
                    if (r_cnt == L_COLS_CNT) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end else begin
                        r_wen  <= 1'b1;
                        r_addr <= w_line_addr;
                        r_din  <= CH_SPACE;
                        r_cnt  <= r_cnt + CNT_W'(1);
                    end
                end
                ST_CLEAR_SCREEN: begin
                    if (r_cnt == L_CELLS_CNT) begin
                        r_state    <= ST_IDLE;
                        r_ready    <= 1'b1;
                        r_col      <= '0;
                        r_row      <= '0;
                        r_row_base <= '0;
                    end else begin
                        r_wen  <= 1'b1;
                        r_addr <= ADDR_W'(r_cnt);
                        r_din  <= CH_SPACE;
                        r_cnt  <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buffer_writer.sv
// Directed self-checking bench for buffer_writer (default 80x24 geometry).
module tb_buffer_writer;

    logic        pclk;
    logic        clr;
    logic [7:0]  data;
    logic        valid;
    logic        ready;
    logic [10:0] buffer_addr;
    logic [7:0]  buffer_din;
    logic        buffer_wen;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;

    int checks = 0;
    int errors = 0;

    buffer_writer #(.COLS(80), .ROWS(24)) dut (
        .pclk        (pclk),
        .clr         (clr),
        .data        (data),
        .valid       (valid),
        .ready       (ready),
        .buffer_addr (buffer_addr),
        .buffer_din  (buffer_din),
        .buffer_wen  (buffer_wen),
        .cursor_col  (cursor_col),
        .cursor_row  (cursor_row)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Called at a negedge; returns at the negedge right after the transfer edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 5000) begin
            @(negedge pclk);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL send_wait ready never rose, got %0b required 1", ready);
        end
        data  = b;
        valid = 1'b1;
        @(negedge pclk);
        valid = 1'b0;
    endtask

    task automatic do_reset();
        clr   = 1'b1;
        valid = 1'b0;
        data  = 8'h00;
        repeat (3) @(negedge pclk);
        clr = 1'b0;
        @(negedge pclk);
    endtask

    task automatic test_reset();
        clr   = 1'b1;
        valid = 1'b0;
        data  = 8'h00;
        repeat (3) @(negedge pclk);
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b required 0", ready); end
        checks++;
        if (buffer_wen !== 1'b0 || buffer_addr !== 11'd0 || buffer_din !== 8'd0) begin
            errors++;
            $display("FAIL reset_buf got wen=%0b addr=%0d din=%h required 0/0/00", buffer_wen, buffer_addr, buffer_din);
        end
        checks++;
        if (cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
            errors++;
            $display("FAIL reset_cursor got col=%0d row=%0d required 0/0", cursor_col, cursor_row);
        end
        clr = 1'b0;
        @(negedge pclk);
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %0b required 1", ready); end
    endtask

    task automatic test_printable();
        do_reset();
        send_byte(8'h41);
        checks++;
        if (buffer_wen !== 1'b1 || buffer_addr !== 11'd0 || buffer_din !== 8'h41) begin
            errors++;
            $display("FAIL print_A got wen=%0b addr=%0d din=%h required 1/0/41", buffer_wen, buffer_addr, buffer_din);
        end
        checks++;
        if (cursor_col !== 7'd1) begin errors++; $display("FAIL print_A_col got %0d required 1", cursor_col); end
        @(negedge pclk);
        checks++;
        if (buffer_wen !== 1'b0) begin errors++; $display("FAIL print_wen_drop got %0b required 0", buffer_wen); end
    endtask

    task automatic test_crlf();
        int good;
        do_reset();
        send_byte(8'h48);
        checks++;
        if (buffer_wen !== 1'b1 || buffer_addr !== 11'd0 || buffer_din !== 8'h48) begin
            errors++;
            $display("FAIL crlf_H got wen=%0b addr=%0d din=%h required 1/0/48", buffer_wen, buffer_addr, buffer_din);
        end
        send_byte(8'h49);
        checks++;
        if (buffer_wen !== 1'b1 || buffer_addr !== 11'd1 || buffer_din !== 8'h49) begin
            errors++;
            $display("FAIL crlf_I got wen=%0b addr=%0d din=%h required 1/1/49", buffer_wen, buffer_addr, buffer_din);
        end
        send_byte(8'h0D);
        checks++;
        if (buffer_wen !== 1'b0 || cursor_col !== 7'd0) begin
            errors++;
            $display("FAIL crlf_CR got wen=%0b col=%0d required 0/0", buffer_wen, cursor_col);
        end
        send_byte(8'h0A);
        checks++;
        if (cursor_col !== 7'd0 || cursor_row !== 5'd1) begin
            errors++;
            $display("FAIL crlf_LF_cursor got col=%0d row=%0d required 0/1", cursor_col, cursor_row);
        end
        good = 0;
        for (int i = 0; i < 80; i++) begin
            if (buffer_wen === 1'b1 && buffer_addr === 11'(80 + i) && buffer_din === 8'h20 && ready === 1'b0)
                good++;
            @(negedge pclk);
        end
        checks++;
        if (good !== 80) begin errors++; $display("FAIL crlf_clear_line got %0d good writes required 80", good); end
        checks++;
        if (buffer_wen !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL crlf_clear_end got wen=%0b ready=%0b required 0/1", buffer_wen, ready);
        end
    endtask

    task automatic test_clear_screen();
        int good;
        do_reset();
        repeat (3) send_byte(8'h0A);
        repeat (5) send_byte(8'h61);
        checks++;
        if (cursor_col !== 7'd5 || cursor_row !== 5'd3) begin
            errors++;
            $display("FAIL ff_setup got col=%0d row=%0d required 5/3", cursor_col, cursor_row);
        end
        send_byte(8'h0C);
        good = 0;
        for (int i = 0; i < 1920; i++) begin
            if (buffer_wen === 1'b1 && buffer_addr === 11'(i) && buffer_din === 8'h20 && ready === 1'b0)
                good++;
            @(negedge pclk);
        end
        checks++;
        if (good !== 1920) begin errors++; $display("FAIL ff_writes got %0d good writes required 1920", good); end
        checks++;
        if (cursor_col !== 7'd0 || cursor_row !== 5'd0 || ready !== 1'b1 || buffer_wen !== 1'b0) begin
            errors++;
            $display("FAIL ff_end got col=%0d row=%0d ready=%0b wen=%0b required 0/0/1/0",
                     cursor_col, cursor_row, ready, buffer_wen);
        end
        send_byte(8'h51);
        checks++;
        if (buffer_wen !== 1'b1 || buffer_addr !== 11'd0 || buffer_din !== 8'h51) begin
            errors++;
            $display("FAIL ff_next_char got wen=%0b addr=%0d din=%h required 1/0/51", buffer_wen, buffer_addr, buffer_din);
        end
    endtask

    task automatic test_corner();
        int good;
        do_reset();
        repeat (23) send_byte(8'h0A);
        repeat (79) send_byte(8'h2E);
        checks++;
        if (cursor_col !== 7'd79 || cursor_row !== 5'd23) begin
            errors++;
            $display("FAIL corner_setup got col=%0d row=%0d required 79/23", cursor_col, cursor_row);
        end
        send_byte(8'h5A);
        checks++;
        if (buffer_wen !== 1'b1 || buffer_addr !== 11'd1919 || buffer_din !== 8'h5A) begin
            errors++;
            $display("FAIL corner_Z got wen=%0b addr=%0d din=%h required 1/1919/5A", buffer_wen, buffer_addr, buffer_din);
        end
`ifdef AUTOWRAP_EN
        checks++;
        if (cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
            errors++;
            $display("FAIL corner_wrap got col=%0d row=%0d required 0/0", cursor_col, cursor_row);
        end
        @(negedge pclk);
        good = 0;
        for (int i = 0; i < 80; i++) begin
            if (buffer_wen === 1'b1 && buffer_addr === 11'(i) && buffer_din === 8'h20) good++;
            @(negedge pclk);
        end
        checks++;
        if (good !== 80) begin errors++; $display("FAIL corner_wrap_clear got %0d good writes required 80", good); end
`else
        checks++;
        if (cursor_col !== 7'd79 || cursor_row !== 5'd23) begin
            errors++;
            $display("FAIL corner_stay got col=%0d row=%0d required 79/23", cursor_col, cursor_row);
        end
        send_byte(8'h59);
        checks++;
        if (buffer_addr !== 11'd1919 || buffer_din !== 8'h59 || cursor_col !== 7'd79) begin
            errors++;
            $display("FAIL corner_overwrite got addr=%0d din=%h col=%0d required 1919/59/79",
                     buffer_addr, buffer_din, cursor_col);
        end
        send_byte(8'h0A);
        checks++;
        if (cursor_row !== 5'd0 || buffer_wen !== 1'b1 || buffer_addr !== 11'd0 || cursor_col !== 7'd79) begin
            errors++;
            $display("FAIL corner_lf_wrap got row=%0d wen=%0b addr=%0d col=%0d required 0/1/0/79",
                     cursor_row, buffer_wen, buffer_addr, cursor_col);
        end
        good = 0;
        for (int i = 0; i < 80; i++) begin
            if (buffer_wen === 1'b1 && buffer_addr === 11'(i)) good++;
            @(negedge pclk);
        end
        checks++;
        if (good !== 80) begin errors++; $display("FAIL corner_lf_clear got %0d good writes required 80", good); end
`endif
    endtask

    task automatic test_ignored();
        do_reset();
        send_byte(8'h08);
        checks++;
        if (buffer_wen !== 1'b0 || cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
            errors++;
            $display("FAIL bs_col0 got wen=%0b col=%0d row=%0d required 0/0/0", buffer_wen, cursor_col, cursor_row);
        end
        send_byte(8'h00);
        checks++;
        if (buffer_wen !== 1'b0 || cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
            errors++;
            $display("FAIL nul got wen=%0b col=%0d row=%0d required 0/0/0", buffer_wen, cursor_col, cursor_row);
        end
        send_byte(8'h61);
        send_byte(8'h62);
        send_byte(8'h08);
        checks++;
        if (buffer_wen !== 1'b0 || cursor_col !== 7'd1) begin
            errors++;
            $display("FAIL bs_dec got wen=%0b col=%0d required 0/1", buffer_wen, cursor_col);
        end
        send_byte(8'h63);
        checks++;
        if (buffer_addr !== 11'd1 || buffer_din !== 8'h63 || cursor_col !== 7'd2) begin
            errors++;
            $display("FAIL bs_overwrite got addr=%0d din=%h col=%0d required 1/63/2", buffer_addr, buffer_din, cursor_col);
        end
    endtask

    task automatic test_back_to_back();
        int good;
        do_reset();
        good  = 0;
        data  = 8'h30;
        valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge pclk);
            if (buffer_wen === 1'b1 && buffer_addr === 11'(i) && buffer_din === 8'(8'h30 + i) && ready === 1'b1)
                good++;
            data = 8'(8'h31 + i);
        end
        valid = 1'b0;
        checks++;
        if (good !== 8) begin errors++; $display("FAIL b2b_writes got %0d good writes required 8", good); end
        checks++;
        if (cursor_col !== 7'd8) begin errors++; $display("FAIL b2b_col got %0d required 8", cursor_col); end
    endtask

    task automatic test_clr_abort();
        int wr;
        do_reset();
        send_byte(8'h0C);
        repeat (100) @(negedge pclk);
        checks++;
        if (buffer_wen !== 1'b1 || buffer_addr !== 11'd100) begin
            errors++;
            $display("FAIL abort_pre got wen=%0b addr=%0d required 1/100", buffer_wen, buffer_addr);
        end
        clr = 1'b1;
        @(negedge pclk);
        checks++;
        if (buffer_wen !== 1'b0 || buffer_addr !== 11'd0 || buffer_din !== 8'd0 || ready !== 1'b0 ||
            cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
            errors++;
            $display("FAIL abort_reset got wen=%0b addr=%0d din=%h ready=%0b col=%0d row=%0d required all 0",
                     buffer_wen, buffer_addr, buffer_din, ready, cursor_col, cursor_row);
        end
        @(negedge pclk);
        clr = 1'b0;
        wr = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge pclk);
            if (buffer_wen !== 1'b0) wr++;
        end
        checks++;
        if (wr !== 0) begin errors++; $display("FAIL abort_no_writes got %0d writes required 0", wr); end
        send_byte(8'h42);
        checks++;
        if (buffer_wen !== 1'b1 || buffer_addr !== 11'd0 || buffer_din !== 8'h42) begin
            errors++;
            $display("FAIL abort_next_B got wen=%0b addr=%0d din=%h required 1/0/42", buffer_wen, buffer_addr, buffer_din);
        end
    endtask

    initial begin
        clr   = 1'b1;
        valid = 1'b0;
        data  = 8'h00;
        @(negedge pclk);
        test_reset();
        test_printable();
        test_crlf();
        test_clear_screen();
        test_corner();
        test_ignored();
        test_back_to_back();
        test_clr_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
